// File: rtl/random_prefetch.sv
// Prefetch FIFO in front of the random number device. A RUN/DRAIN/WRITE/SETTLE
// sequencer reseeds the device without letting words from the old seed escape.
module random_prefetch #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   rngRead,
    output logic                   rngWrite,
    output logic [31:0]            rngDataOut,
    input  logic                   rngReadValid,
    input  logic [31:0]            rngDataIn,
    output logic                   outValid,
    output logic [31:0]            outData,
    input  logic                   outReady,
    input  logic                   seedWrite,
    input  logic [31:0]            seedData,
    output logic                   seedBusy,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW        = $clog2(DEPTH);
    localparam int CW        = AW + 1;
    localparam int SW        = $clog2(SETTLE + 1);
    localparam int SETTLE_M1 = SETTLE - 1;
    localparam logic [CW:0]   DEPTH_W     = DEPTH[CW:0];
    localparam logic [SW-1:0] SETTLE_LAST = SETTLE_M1[SW-1:0];

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_WRITE  = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    state_t         state_r, state_next_s;
    logic [31:0]    mem_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r, rd_ptr_r, wr_ptr_next_s, rd_ptr_next_s;
    logic [CW-1:0]  count_r, count_next_s, remain_s;
    logic [CW:0]    in_flight_s;
    logic [1:0]     outstanding_r, outst_next_s;
    logic [SW-1:0]  settle_cnt_r;
    logic [31:0]    seed_r, out_data_r, head_next_s, rng_data_out_r, data_out_next_s;
    logic           rng_read_r, rng_write_r, out_valid_r, seed_busy_r;
    logic           rd_next_s, wr_next_s, busy_next_s, valid_next_s;
    logic           seed_accept_s, push_s, pop_s, flush_s;

    assign seed_accept_s = (state_r == ST_RUN) && seedWrite && !seed_busy_r;
    // Responses arriving outside RUN belong to the old seed and are dropped.
    assign push_s        = rngReadValid && (state_r == ST_RUN);
    assign pop_s         = out_valid_r && outReady;
    assign flush_s       = (state_r == ST_DRAIN) && (state_next_s == ST_WRITE);

    // Sequencer state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Sequencer next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (seed_accept_s) state_next_s = ST_DRAIN;
                else               state_next_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (outstanding_r == 2'd0) state_next_s = ST_WRITE;
                else                       state_next_s = ST_DRAIN;
            end
            ST_WRITE: state_next_s = ST_SETTLE;
            ST_SETTLE: begin
                if (settle_cnt_r == SETTLE_LAST) state_next_s = ST_RUN;
                else                             state_next_s = ST_SETTLE;
            end
            default: state_next_s = ST_RUN;
        endcase
    end

    // Sequencer outputs, computed one cycle ahead so every port is a flop
    always_comb begin
        rd_next_s       = 1'b0;
        wr_next_s       = 1'b0;
        busy_next_s     = 1'b1;
        data_out_next_s = 32'd0;
        // Words already owned: stored, awaiting response, and the read now on the bus.
        in_flight_s = {1'b0, count_r} + {{(CW - 1){1'b0}}, outstanding_r}
                    + {{CW{1'b0}}, rng_read_r};
        if (state_next_s == ST_RUN) begin
            busy_next_s = 1'b0;
            if (in_flight_s < DEPTH_W) rd_next_s = 1'b1;
            else                       rd_next_s = 1'b0;
        end else begin
            busy_next_s = 1'b1;
            rd_next_s   = 1'b0;
        end
        if (state_next_s == ST_WRITE) begin
            wr_next_s       = 1'b1;
            data_out_next_s = seed_r;
        end else begin
            wr_next_s       = 1'b0;
            data_out_next_s = 32'd0;
        end
    end

    // Outstanding device responses
    always_comb begin
        outst_next_s = outstanding_r;
        case ({rng_read_r, rngReadValid && (outstanding_r != 2'd0)})
            2'b10:   outst_next_s = outstanding_r + 2'd1;
            2'b01:   outst_next_s = outstanding_r - 2'd1;
            default: outst_next_s = outstanding_r;
        endcase
    end

    // FIFO pointer/count update and show-ahead head selection
    always_comb begin
        count_next_s  = count_r;
        rd_ptr_next_s = rd_ptr_r;
        wr_ptr_next_s = wr_ptr_r;
        head_next_s   = out_data_r;
        valid_next_s  = 1'b0;
        remain_s      = count_r - {{(CW - 1){1'b0}}, pop_s};
        if (flush_s) begin
            count_next_s  = {CW{1'b0}};
            rd_ptr_next_s = {AW{1'b0}};
            wr_ptr_next_s = {AW{1'b0}};
            head_next_s   = out_data_r;
            valid_next_s  = 1'b0;
        end else begin
            count_next_s  = remain_s + {{(CW - 1){1'b0}}, push_s};
            rd_ptr_next_s = rd_ptr_r + {{(AW - 1){1'b0}}, pop_s};
            wr_ptr_next_s = wr_ptr_r + {{(AW - 1){1'b0}}, push_s};
            if (remain_s != {CW{1'b0}}) begin
                head_next_s  = mem_r[rd_ptr_next_s];
                valid_next_s = 1'b1;
            end else if (push_s) begin
                head_next_s  = rngDataIn;
                valid_next_s = 1'b1;
            end else begin
                head_next_s  = out_data_r;
                valid_next_s = 1'b0;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rng_read_r     <= 1'b0;
            rng_write_r    <= 1'b0;
            rng_data_out_r <= 32'd0;
            seed_busy_r    <= 1'b0;
            seed_r         <= 32'd0;
            outstanding_r  <= 2'd0;
            settle_cnt_r   <= {SW{1'b0}};
            count_r        <= {CW{1'b0}};
            rd_ptr_r       <= {AW{1'b0}};
            wr_ptr_r       <= {AW{1'b0}};
            out_data_r     <= 32'd0;
            out_valid_r    <= 1'b0;
        end else begin
            rng_read_r     <= rd_next_s;
            rng_write_r    <= wr_next_s;
            rng_data_out_r <= data_out_next_s;
            seed_busy_r    <= busy_next_s;
            outstanding_r  <= outst_next_s;
            count_r        <= count_next_s;
            rd_ptr_r       <= rd_ptr_next_s;
            wr_ptr_r       <= wr_ptr_next_s;
            out_data_r     <= head_next_s;
            out_valid_r    <= valid_next_s;
            if (state_r == ST_SETTLE) settle_cnt_r <= settle_cnt_r + {{(SW - 1){1'b0}}, 1'b1};
            else                      settle_cnt_r <= {SW{1'b0}};
            if (seed_accept_s) seed_r <= seedData;
            else               seed_r <= seed_r;
        end
    end

    // FIFO storage; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= rngDataIn;
    end

    assign rngRead    = rng_read_r;
    assign rngWrite   = rng_write_r;
    assign rngDataOut = rng_data_out_r;
    assign outValid   = out_valid_r;
    assign outData    = out_data_r;
    assign seedBusy   = seed_busy_r;
    assign count      = count_r;

endmodule

// File: doc/random_prefetch.md
Name: random_prefetch

Overview:
- Sits directly downstream of the random number device and drives its read, write and dataIn inputs.
- Consumes its readValid and dataOut.
- Keeps a small FIFO of pre-fetched 32-bit random words so consumers get a value with zero wait, through a valid/ready port.
- Also sequences reseeding: drains in-flight reads, forwards the seed write, flushes stale words, then resumes prefetch.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16.
SETTLE, 3, idle cycles after a seed write before the next read is issued; minimum 3.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
rngRead  output  1  one-cycle read request to the random device
rngWrite  output  1  one-cycle seed write to the random device
rngDataOut  output  32  seed value; meaningful only with rngWrite
rngReadValid  input  1  device response strobe, 2 cycles after rngRead
rngDataIn  input  32  device random word, valid with rngReadValid
outValid  output  1  FIFO head available
outData  output  32  FIFO head word (show-ahead)
outReady  input  1  consumer accepts head; pop when outValid && outReady
seedWrite  input  1  request to reseed with seedData
seedData  input  32  seed value, sampled with seedWrite
seedBusy  output  1  reseed sequence in progress; seedWrite ignored while 1
count  output  $clog2(DEPTH)+1  words currently held in FIFO

Behaviour:
- Reset (reset=0, asynchronous), all outputs 0:
  - rngRead, rngWrite, rngDataOut, outValid, outData, seedBusy, count = 0.
  - FIFO empty, outstanding counter 0, state RUN.
- Device timing:
  - rngRead at cycle t gives rngReadValid and rngDataIn at t+2.
  - Reads may be issued back-to-back; up to 2 responses can be in flight.
  - outstanding counter (0..2): +1 on rngRead, -1 on rngReadValid, both in one cycle = no change.
- Prefetch:
  - In RUN, rngRead=1 (registered) whenever count + outstanding + push-pending < DEPTH.
  - The FIFO can never overflow.
  - A pop in the same cycle does not allow an extra read that cycle; the condition is evaluated on registered state only.
- Push: when rngReadValid=1 and not discarding, rngDataIn is written to the FIFO.
  - It is visible on outData/outValid the next cycle if the FIFO was empty.
  - First word after reset release: rngRead in cycle 1, response cycle 3, outValid=1 by cycle 4.
- Pop: when outValid && outReady, the head advances at the clock edge.
  - Simultaneous push and pop leaves count unchanged.
  - outData holds its last value when the FIFO goes empty; outValid=0.
- State machine RUN -> DRAIN -> WRITE -> SETTLE -> RUN:
  - RUN: seedWrite=1 with seedBusy=0 latches seedData, sets seedBusy=1 next cycle, goes to DRAIN. No new rngRead from that cycle.
  - DRAIN: wait until outstanding=0; arriving responses are discarded (not pushed). Then go to WRITE.
  - WRITE: rngWrite=1 and rngDataOut=latched seed for exactly one cycle. The FIFO is flushed (count=0, outValid=0) in the same cycle. Go to SETTLE.
  - SETTLE: count SETTLE cycles with no reads, then go to RUN and clear seedBusy.
- Consumer side during reseed: FIFO words present before the flush remain poppable during DRAIN.
  - A pop in the same cycle as seedWrite completes normally.
- seedWrite while seedBusy=1 is ignored; no queuing.
- Reset asserted mid-sequence aborts it; all state returns to reset values and prefetch restarts from empty.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset release with no consumer pops: exactly DEPTH=4 rngRead pulses, count settles at 4, outValid=1 by cycle 4, rngRead stays 0 afterwards.
- Device model returning 0x1000+n with outReady held 1: one word popped per cycle after fill, values strictly in issue order 0x1000, 0x1001, ..., no gaps or duplicates.
- Backpressure: outReady toggles 1,0,1,0 for 20 cycles: count never exceeds 4, outstanding never exceeds 2, no word lost.
- seedWrite=1, seedData=0xDEADBEEF while 2 reads in flight: the 2 responses are discarded, then a single rngWrite with rngDataOut=0xDEADBEEF. count=0 the next cycle, no rngRead for 3 cycles, then refill; seedBusy high from the cycle after seedWrite through SETTLE.
- seedWrite pulsed again while seedBusy=1: no second rngWrite is issued.
- reset driven to 0 during DRAIN: all outputs 0 immediately (asynchronous). After release, normal fill with no rngWrite issued.
